// File: rtl/reg_file_mp.sv
// Multi-ported register file with same-cycle write bypass and a per-register
// pending-write scoreboard used by issue logic to track operand readiness.
module reg_file_mp #(
    parameter int addr_width_p = 6,
    parameter int data_width_p = 32,
    parameter int num_read_p   = 2,
    parameter int num_write_p  = 2,
    parameter int zero_reg_p   = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [num_write_p-1:0]              wen_i,
    input  logic [num_write_p*addr_width_p-1:0] waddr_i,
    input  logic [num_write_p*data_width_p-1:0] wdata_i,
    input  logic [num_read_p*addr_width_p-1:0]  raddr_i,
    output logic [num_read_p*data_width_p-1:0]  rdata_o,
    output logic [num_read_p-1:0]               rready_o,
    input  logic                                alloc_i,
    input  logic [addr_width_p-1:0]             alloc_addr_i,
    output logic [addr_width_p:0]               pending_cnt_o
);

    localparam int depth_lp = 1 << addr_width_p;

    logic [data_width_p-1:0] mem_q [depth_lp];
    logic [depth_lp-1:0]     pend_q;
    logic [depth_lp-1:0]     pend_n;
    logic [addr_width_p:0]   cnt_q;
    logic [addr_width_p:0]   cnt_n;

    // Address 0 is immune to writes and allocation when it is the zero register.
    function automatic logic wr_ok(input logic [addr_width_p-1:0] a);
        return !((zero_reg_p != 0) && (a == '0));
    endfunction

    // Clears from writes are applied before the allocation so that a
    // same-address alloc overrides the clear.
    always_comb begin
        pend_n = pend_q;
        for (int k = 0; k < num_write_p; k++) begin
            if (wen_i[k] && wr_ok(waddr_i[k*addr_width_p +: addr_width_p]))
                pend_n[waddr_i[k*addr_width_p +: addr_width_p]] = 1'b0;
        end
        if (alloc_i && wr_ok(alloc_addr_i))
            pend_n[alloc_addr_i] = 1'b1;
        cnt_n = '0;
        for (int i = 0; i < depth_lp; i++)
            cnt_n = cnt_n + (addr_width_p+1)'(pend_n[i]);
    end

    // Ascending port order: the highest-index matching port is assigned last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth_lp; i++)
                mem_q[i] <= '0;
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            for (int k = 0; k < num_write_p; k++) begin
                if (wen_i[k] && wr_ok(waddr_i[k*addr_width_p +: addr_width_p]))
                    mem_q[waddr_i[k*addr_width_p +: addr_width_p]] <=
                        wdata_i[k*data_width_p +: data_width_p];
            end
            pend_q <= pend_n;
            cnt_q  <= cnt_n;
        end
    end

    always_comb begin
        logic [addr_width_p-1:0] ra;
        logic                    hit;
        logic [data_width_p-1:0] byp;
        rdata_o  = '0;
        rready_o = '0;
        for (int r = 0; r < num_read_p; r++) begin
            ra  = raddr_i[r*addr_width_p +: addr_width_p];
            hit = 1'b0;
            byp = '0;
            for (int k = 0; k < num_write_p; k++) begin
                if (wen_i[k] && (waddr_i[k*addr_width_p +: addr_width_p] == ra)) begin
                    hit = 1'b1;
                    byp = wdata_i[k*data_width_p +: data_width_p];
                end
            end
            if ((zero_reg_p != 0) && (ra == '0)) begin
                rdata_o[r*data_width_p +: data_width_p] = '0;
                rready_o[r] = 1'b1;
            end else if (hit) begin
                rdata_o[r*data_width_p +: data_width_p] = byp;
                rready_o[r] = 1'b1;
            end else begin
                rdata_o[r*data_width_p +: data_width_p] = mem_q[ra];
                rready_o[r] = !pend_q[ra];
            end
        end
    end

    assign pending_cnt_o = cnt_q;

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Multi-ported, parametrised register file with per-register pending-write scoreboard for the pipelined datapath. It provides any number of combinational read ports and several write ports with same-cycle write-to-read bypass. It also provides an optional hardwired-zero register and a full asynchronous reset. Issue logic uses the scoreboard to allocate destination registers and to see, per read port, whether the operand is ready. It sits between decode/issue (reads, allocation) and writeback (writes).

## Interface
Parameters:
- addr_width_p, 6: register address width; depth = 2**addr_width_p
- data_width_p, 32: register data width
- num_read_p, 2: number of read ports (≥1)
- num_write_p, 2: number of write ports (≥1)
- zero_reg_p, 1: 1 = register 0 reads 0, ignores writes and allocation, always ready

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wen_i  in  num_write_p  per-port write enable
- waddr_i  in  num_write_p*addr_width_p  write addresses, port k at bits [k*addr_width_p +: addr_width_p]
- wdata_i  in  num_write_p*data_width_p  write data, packed as waddr_i
- raddr_i  in  num_read_p*addr_width_p  read addresses, packed
- rdata_o  out  num_read_p*data_width_p  read data, packed
- rready_o  out  num_read_p  per read port: operand valid (not pending, or written this cycle)
- alloc_i  in  1  mark alloc_addr_i pending
- alloc_addr_i  in  addr_width_p  destination being allocated
- pending_cnt_o  out  addr_width_p+1  number of pending registers (registered)

## Operation
- Storage: 2**addr_width_p × data_width_p array and a pending bit vector of the same depth.
- Reset (rst_n=0): all registers cleared to 0, all pending bits cleared, pending_cnt_o=0. Reset mid-operation discards in-flight writes and allocations that cycle.
- Write: for each k with wen_i[k]=1, store wdata_i[k] at waddr_i[k] on the rising edge.
- Write-port conflict: if several enabled ports target the same address, the highest-index port wins, for both storage and bypass.
- Read (combinational): for port r, the output is one of the following, in priority order:
  - 0 if zero_reg_p=1 and raddr=0;
  - otherwise wdata of the highest-index enabled write port matching raddr (bypass);
  - otherwise the array contents.
- rready_o[r]=1 if any of these holds:
  - zero_reg_p=1 and raddr=0;
  - the pending bit for raddr is 0;
  - an enabled write port matches raddr this cycle.
  Allocation in the same cycle does not affect that cycle's rready_o.
- Scoreboard: an enabled write clears the pending bit of its address. alloc_i sets the pending bit of alloc_addr_i.
  - Simultaneous write-clear and alloc-set on the same address: set wins, so the bit ends at 1.
  - Allocating an already-pending register leaves its bit at 1.
  - Writing a non-pending register leaves its bit at 0.
- pending_cnt_o = popcount of the pending vector after the edge, registered. It changes by at most +1/−num_write_p per cycle and never exceeds 2**addr_width_p.
- zero_reg_p=1: writes and allocation to address 0 are ignored. Pending bit 0 is constant 0.

## Timing
- Read latency 0 (combinational from raddr_i, wen_i, waddr_i, wdata_i and state).
- Write and pending updates take effect at the next rising edge and are visible on array reads from the following cycle.
- pending_cnt_o reflects state after each edge, with 1-cycle latency from alloc_i or wen_i.
- No handshake or stall. Issue logic must gate its use of operands on rready_o.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 asynchronously between edges → rdata for r5 reads 0 immediately; pending_cnt_o=0.
- Bypass and priority:
  - wen_i=2'b11, both ports to r7, port0=0x1111, port1=0x2222; read r7 same cycle → 0x2222.
  - Next cycle with no write → r7 reads 0x2222.
- Scoreboard:
  - Cycle 0: alloc r3 → r3 reads rready=0 from cycle 1, pending_cnt_o=1.
  - Cycle 4: write r3=0x55 → rready=1 and data 0x55 in cycle 4.
  - Cycle 5: pending_cnt_o=0.
- Simultaneous events: r9 pending; in one cycle write r9 and alloc r9 → r9 still pending next cycle, pending_cnt_o unchanged at 1.
- Zero register (zero_reg_p=1):
  - Write 0xFFFF to r0 and alloc r0 → r0 reads 0, rready=1, pending_cnt_o=0.
  - With zero_reg_p=0, the same write stores 0xFFFF.
- Full scoreboard: alloc every register 1..63 (zero_reg_p=1, addr_width_p=6) → pending_cnt_o=63; then two writes per cycle drain it to 0 in 32 cycles.
